// File: rtl/hart_cluster_dmem_arbiter_if.sv
// hart_cluster_dmem_arbiter_if: per-hart request channels plus the shared data-memory port
interface hart_cluster_dmem_arbiter_if #(
  parameter int NUM_HARTS = 2,
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32
);
  localparam int HW = $clog2(NUM_HARTS);
  logic [NUM_HARTS-1:0]        h_mem_read;
  logic [NUM_HARTS-1:0]        h_wen;
  logic [NUM_HARTS-1:0]        h_atomic;
  logic [NUM_HARTS*ADDR_W-1:0] h_addr;
  logic [NUM_HARTS*XLEN-1:0]   h_wd;
  logic [NUM_HARTS*4-1:0]      h_byte_en;
  logic [NUM_HARTS-1:0]        h_data_ready;
  logic [XLEN-1:0]             h_read_data;
  logic                        dm_mem_read;
  logic                        dm_wen;
  logic [ADDR_W-1:0]           dm_addr;
  logic [XLEN-1:0]             dm_wd;
  logic [3:0]                  dm_byte_en;
  logic                        dm_data_ready;
  logic [XLEN-1:0]             dm_read_data;
  logic [HW-1:0]               grant;
  logic                        timeout;
  // master: the harts and the memory model around the arbiter
  modport master (
    output h_mem_read, h_wen, h_atomic, h_addr, h_wd, h_byte_en, dm_data_ready, dm_read_data,
    input  h_data_ready, h_read_data, dm_mem_read, dm_wen, dm_addr, dm_wd, dm_byte_en, grant, timeout
  );
  // slave: the arbiter itself
  modport slave (
    input  h_mem_read, h_wen, h_atomic, h_addr, h_wd, h_byte_en, dm_data_ready, dm_read_data,
    output h_data_ready, h_read_data, dm_mem_read, dm_wen, dm_addr, dm_wd, dm_byte_en, grant, timeout
  );
endinterface

// File: rtl/hart_cluster_dmem_arbiter.sv
// hart_cluster_dmem_arbiter: round-robin sharing of one data-memory port among harts, with AMO lock and watchdog
module hart_cluster_dmem_arbiter #(
  parameter int NUM_HARTS = 2,
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input logic clk,
  input logic rst_n,
  hart_cluster_dmem_arbiter_if.slave bus
);
  localparam int HW = $clog2(NUM_HARTS);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;
  state_t               state, state_nxt;
  logic [HW-1:0]        grant, rr_ptr, pick, sel, grant_inc;
  logic [NUM_HARTS-1:0] req;
  logic                 found, phase, done, expire, take, lock_next;
  logic                 lat_rd, lat_wen, lat_atomic;
  logic [ADDR_W-1:0]    lat_addr;
  logic [XLEN-1:0]      lat_wd;
  logic [3:0]           lat_be;
  logic [CW-1:0]        wd_cnt;
  assign req       = bus.h_mem_read | bus.h_wen;
  assign grant_inc = (grant == HW'(NUM_HARTS - 1)) ? '0 : grant + 1'b1;
  assign done      = (state == BUSY) && bus.dm_data_ready;
  assign expire    = (state != IDLE) && !done && (wd_cnt == CW'(TIMEOUT));
  assign lock_next = lat_atomic && !phase;
  assign take      = (state == IDLE) ? found : (state == LOCKED) && req[grant] && !expire;
  assign sel       = (state == IDLE) ? pick : grant;
  // first requester at or after rr_ptr; scanning downward lets the nearest one win
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int i = NUM_HARTS - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % NUM_HARTS]) begin
        pick  = HW'((int'(rr_ptr) + i) % NUM_HARTS);
        found = 1'b1;
      end
  end
  // next state: abort beats everything, completion beats a new grant
  always_comb begin
    state_nxt = expire ? IDLE : done ? (lock_next ? LOCKED : IDLE) : take ? BUSY : state;
  end
  // control state, grant pointer, AMO phase and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      phase  <= 1'b0;
      wd_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (take) grant <= sel;
      if (expire || (done && !lock_next)) begin
        rr_ptr <= grant_inc;
        phase  <= 1'b0;
      end else if (done) phase <= 1'b1;
      wd_cnt <= (state == IDLE) ? '0 : (done || expire) ? wd_cnt : wd_cnt + 1'b1;
    end
  end
  // latched copy of the granted hart's request, held stable while BUSY
  always_ff @(posedge clk) begin
    if (take) begin
      lat_rd     <= bus.h_mem_read[sel];
      lat_wen    <= bus.h_wen[sel];
      lat_atomic <= bus.h_atomic[sel];
      lat_addr   <= bus.h_addr[sel*ADDR_W +: ADDR_W];
      lat_wd     <= bus.h_wd[sel*XLEN +: XLEN];
      lat_be     <= bus.h_byte_en[sel*4 +: 4];
    end
  end
  assign bus.dm_mem_read  = (state == BUSY) && lat_rd;
  assign bus.dm_wen       = (state == BUSY) && lat_wen;
  assign bus.dm_addr      = (state == BUSY) ? lat_addr : '0;
  assign bus.dm_wd        = (state == BUSY) ? lat_wd : '0;
  assign bus.dm_byte_en   = (state == BUSY) ? lat_be : '0;
  assign bus.h_data_ready = (done || expire) ? NUM_HARTS'(1) << grant : '0;
  assign bus.h_read_data  = done ? bus.dm_read_data : '0;
  assign bus.grant        = grant;
  assign bus.timeout      = expire;
endmodule
